// File: rtl/sram_seq_pkg.sv
// Shared definitions for the SRAM request sequencer slice.
//   ADDR_W / DATA_W : SRAM word address and data widths (DE2-115 SRAM)
//   ST_*            : sequencer FSM state encodings (3-bit, legacy-compatible)
//   fifo_entry_t    : one buffered client command {we, addr, wdata}
package sram_seq_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_VISSUE = 3'd3;
  localparam logic [2:0] ST_VWAIT  = 3'd4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } fifo_entry_t;

endpackage

// File: rtl/sram_req_sequencer_if.sv
// Client-side and controller-side bus of the SRAM request sequencer.
//   req_*  : client command channel (valid/ready)
//   rsp_*  : read response back to the client (single-cycle valid pulse)
//   ctl_*  : controller channel (start pulse, done pulse)
// Handshake rules: a request transfers on a rising clk_50 edge where
// req_valid && req_ready; the client holds req_* stable while req_valid is
// high and not yet accepted. req_ready never depends combinationally on
// req_valid. ctl_start is a one-cycle pulse; ctl_we/addr/wdata are held from
// start until the matching ctl_done pulse; ctl_rdata is valid only with
// ctl_done. rsp_valid is a one-cycle pulse, rsp_rdata holds until the next.
// Modports: master = the sequencer, slave = the client/controller side.
interface sram_req_sequencer_if;
  import sram_seq_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              ctl_start;
  logic              ctl_we;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_done;
  logic [DATA_W-1:0] ctl_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, ctl_done, ctl_rdata,
    output req_ready, rsp_valid, rsp_rdata, ctl_start, ctl_we, ctl_addr,
           ctl_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, ctl_done, ctl_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ctl_start, ctl_we, ctl_addr,
           ctl_wdata
  );

endinterface

// File: rtl/sram_seq_fifo.sv
// Synchronous FIFO of command entries.
//   clk_50, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata   : write an entry (ignored when full)
//   pop, rdata    : rdata shows the head; pop discards it (ignored when empty)
//   full, empty   : decoded from the registered occupancy count
//   count         : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sram_seq_fifo
  import sram_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_50,
  input  logic                   rst_n,
  input  logic                   push,
  input  fifo_entry_t            wdata,
  input  logic                   pop,
  output fifo_entry_t            rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fifo_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_50) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_sequencer.sv
// Upstream command stage for the DE2-115 SRAM controller. Buffers client
// requests in a FIFO and issues them one at a time over a start/done
// handshake, returns read data, and flags controller timeouts.
//   clk_50, rst_n : 50 MHz clock, asynchronous active-low reset
//   bus           : sram_req_sequencer_if.master (req_*, rsp_*, ctl_*)
//   busy          : FIFO non-empty or FSM not idle
//   timeout_err   : sticky, set when a WAIT/VWAIT exceeds TIMEOUT_CYC cycles
//   verify_err    : sticky write-verify mismatch (tied 0 without the macro)
//   state_dbg     : current FSM state encoding
// Optional feature: define SRAM_SEQ_VERIFY_EN to read back every write and
// compare it against the written data (VISSUE/VWAIT states).
module sram_req_sequencer
  import sram_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk_50,
  input  logic                 rst_n,
  sram_req_sequencer_if.master bus,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 verify_err,
  output logic [2:0]           state_dbg
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [2:0]            state_q;
  logic [TW-1:0]         wait_cnt;
  logic                  ctl_start_q;
  logic                  ctl_we_q;
  logic [ADDR_W-1:0]     ctl_addr_q;
  logic [DATA_W-1:0]     ctl_wdata_q;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic                  timeout_q;
  fifo_entry_t           push_entry;
  fifo_entry_t           head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  do_pop;
  logic                  timed_out;

  assign push_entry = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
  // The head is consumed on the single ISSUE cycle.
  assign do_pop     = (state_q == ST_ISSUE);
  assign timed_out  = (wait_cnt == TO_LAST);

  sram_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .push   (bus.req_valid && bus.req_ready),
    .wdata  (push_entry),
    .pop    (do_pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Ready comes straight from the registered occupancy, so a pop while full
  // only reopens the request channel on the following cycle.
  assign bus.req_ready = !fifo_full;
  assign bus.ctl_start = ctl_start_q;
  assign bus.ctl_we    = ctl_we_q;
  assign bus.ctl_addr  = ctl_addr_q;
  assign bus.ctl_wdata = ctl_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = (fifo_count != '0) || (state_q != ST_IDLE);
  assign timeout_err   = timeout_q;
  assign state_dbg     = state_q;

`ifdef SRAM_SEQ_VERIFY_EN
  logic verify_q;
  assign verify_err = verify_q;
`else
  assign verify_err = 1'b0;
`endif

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt    <= '0;
      ctl_start_q <= 1'b0;
      ctl_we_q    <= 1'b0;
      ctl_addr_q  <= '0;
      ctl_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      timeout_q   <= 1'b0;
`ifdef SRAM_SEQ_VERIFY_EN
      verify_q    <= 1'b0;
`endif
    end else begin
      // Both strobes are single-cycle pulses unless re-asserted below.
      ctl_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          ctl_start_q <= 1'b1;
          ctl_we_q    <= head.we;
          ctl_addr_q  <= head.addr;
          ctl_wdata_q <= head.wdata;
          wait_cnt    <= '0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.ctl_done) begin
            if (!ctl_we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= bus.ctl_rdata;
              state_q     <= ST_IDLE;
            end else begin
`ifdef SRAM_SEQ_VERIFY_EN
              state_q <= ST_VISSUE;
`else
              state_q <= ST_IDLE;
`endif
            end
          end else if (timed_out) begin
            // Abort; a read still gets a response so the client never hangs.
            timeout_q <= 1'b1;
            if (!ctl_we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
            end
            state_q <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
`ifdef SRAM_SEQ_VERIFY_EN
        ST_VISSUE: begin
          // Address and write data stay held; only the op type flips to read.
          ctl_start_q <= 1'b1;
          ctl_we_q    <= 1'b0;
          wait_cnt    <= '0;
          state_q     <= ST_VWAIT;
        end
        ST_VWAIT: begin
          if (bus.ctl_done) begin
            if (bus.ctl_rdata != ctl_wdata_q) verify_q <= 1'b1;
            state_q <= ST_IDLE;
          end else if (timed_out) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_sequencer.sv
// Directed self-checking bench for sram_req_sequencer (DEPTH=4,
// TIMEOUT_CYC=64). Inputs are driven and outputs sampled on the falling
// edge of clk_50; the DUT acts on rising edges.
module tb_sram_req_sequencer;
  import sram_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;
  always #10 clk_50 = ~clk_50;

  sram_req_sequencer_if bus();
  logic       busy;
  logic       timeout_err;
  logic       verify_err;
  logic [2:0] state_dbg;

  sram_req_sequencer #(.DEPTH(4), .TIMEOUT_CYC(64)) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err),
    .verify_err  (verify_err),
    .state_dbg   (state_dbg)
  );

`ifdef SRAM_SEQ_VERIFY_EN
  localparam logic [2:0] EXP_POST_WR = ST_VISSUE;
`else
  localparam logic [2:0] EXP_POST_WR = ST_IDLE;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.ctl_done  = 1'b0;
    bus.ctl_rdata = '0;
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic push_op(input logic we, input logic [19:0] addr,
                         input logic [15:0] wdata);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    if (!bus.req_ready) check("push_ready_bound", 64'(bus.req_ready), 64'd1);
    @(posedge clk_50);
    @(negedge clk_50);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin
      @(negedge clk_50);
      n++;
    end while (!bus.ctl_start && n < 200);
    check(tag, 64'(bus.ctl_start), 64'd1);
  endtask

  // Returns on the falling edge right after the rising edge that saw done.
  task automatic pulse_done(input logic [15:0] d);
    bus.ctl_rdata = d;
    bus.ctl_done  = 1'b1;
    @(negedge clk_50);
    bus.ctl_done  = 1'b0;
  endtask

  // Completes the read-back that follows a write when verify is built in.
  task automatic verify_tail(input logic [15:0] d);
`ifdef SRAM_SEQ_VERIFY_EN
    wait_start("verify_start");
    check("verify_we", 64'(bus.ctl_we), 64'd0);
    pulse_done(d);
    check("verify_no_rsp", 64'(bus.rsp_valid), 64'd0);
`else
    if (d == 16'h0) @(negedge clk_50);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    repeat (3) @(negedge clk_50);

    // Reset state
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_ctl", {bus.ctl_start, bus.ctl_we, bus.ctl_addr, bus.ctl_wdata}, 64'd0);
    check("rst_flags", {busy, timeout_err, verify_err, state_dbg}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk_50);

    // 1: write 0x12345 <- BEEF, start at N+2, held until done 8 cycles later
    push_op(1'b1, 20'h12345, 16'hBEEF);
    check("t1_start_N", 64'(bus.ctl_start), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    @(negedge clk_50);
    check("t1_start_N1", 64'(bus.ctl_start), 64'd0);
    check("t1_state_issue", 64'(state_dbg), 64'(ST_ISSUE));
    @(negedge clk_50);
    check("t1_start_N2", 64'(bus.ctl_start), 64'd1);
    check("t1_ctl", {bus.ctl_we, bus.ctl_addr, bus.ctl_wdata}, {1'b1, 20'h12345, 16'hBEEF});
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_50);
      check("t1_hold", {bus.ctl_start, bus.rsp_valid, bus.ctl_we, bus.ctl_addr, bus.ctl_wdata},
            {1'b0, 1'b0, 1'b1, 20'h12345, 16'hBEEF});
    end
    @(negedge clk_50);
    pulse_done(16'h0000);
    check("t1_no_rsp", 64'(bus.rsp_valid), 64'd0);
    check("t1_post_state", 64'(state_dbg), 64'(EXP_POST_WR));
    verify_tail(16'hBEEF);
    @(negedge clk_50);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // 2: read 0x12345, controller returns BEEF
    push_op(1'b0, 20'h12345, 16'h0000);
    wait_start("t2_start");
    check("t2_ctl", {bus.ctl_we, bus.ctl_addr}, {1'b0, 20'h12345});
    repeat (3) @(negedge clk_50);
    check("t2_no_early_rsp", 64'(bus.rsp_valid), 64'd0);
    pulse_done(16'hBEEF);
    check("t2_rsp", {bus.rsp_valid, bus.rsp_rdata}, {1'b1, 16'hBEEF});
    @(negedge clk_50);
    check("t2_rsp_pulse", {bus.rsp_valid, bus.rsp_rdata}, {1'b0, 16'hBEEF});

    // 3: stalled controller, FIFO fills, ready reopens the cycle after pop
    push_op(1'b0, 20'h00100, 16'h0000);
    wait_start("t3_start0");
    for (int i = 1; i <= 4; i++) push_op(1'b1, 20'h00200 + 20'(i), 16'h1000 + 16'(i));
    check("t3_full_ready", 64'(bus.req_ready), 64'd0);
    repeat (3) @(negedge clk_50);
    check("t3_still_full", {bus.req_ready, busy}, {1'b0, 1'b1});
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 20'h00205;
    bus.req_wdata = 16'h1005;
    pulse_done(16'h5A5A);
    check("t3_rsp0", {bus.rsp_valid, bus.rsp_rdata}, {1'b1, 16'h5A5A});
    check("t3_gap_idle", {state_dbg, bus.req_ready}, {ST_IDLE, 1'b0});
    @(negedge clk_50);
    check("t3_issue", {state_dbg, bus.req_ready}, {ST_ISSUE, 1'b0});
    bus.ctl_done = 1'b1;   // done during ISSUE must be ignored
    @(negedge clk_50);
    bus.ctl_done = 1'b0;
    check("t3_pop_ready", {bus.req_ready, bus.ctl_start, bus.ctl_addr}, {1'b1, 1'b1, 20'h00201});
    @(negedge clk_50);
    bus.req_valid = 1'b0;
    check("t3_done_in_issue_ignored", {state_dbg, bus.req_ready}, {ST_WAIT, 1'b0});
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) wait_start("t3_start");
      check("t3_order", {bus.ctl_we, bus.ctl_addr, bus.ctl_wdata},
            {1'b1, 20'h00200 + 20'(i), 16'h1000 + 16'(i)});
      repeat (2) @(negedge clk_50);
      pulse_done(16'h0000);
      check("t3_wr_no_rsp", 64'(bus.rsp_valid), 64'd0);
      verify_tail(16'h1000 + 16'(i));
    end
    @(negedge clk_50);
    check("t3_drained", {busy, timeout_err}, {1'b0, 1'b0});

    // 4: read timeout, late done ignored, queued write proceeds
    push_op(1'b0, 20'h0ABCD, 16'h0000);
    push_op(1'b1, 20'h0BEEF, 16'h7777);
    wait_start("t4_start");
    repeat (63) @(negedge clk_50);
    check("t4_before_to", {timeout_err, bus.rsp_valid}, {1'b0, 1'b0});
    @(negedge clk_50);
    check("t4_timeout", {timeout_err, bus.rsp_valid, bus.rsp_rdata, state_dbg},
          {1'b1, 1'b1, 16'h0000, ST_IDLE});
    bus.ctl_rdata = 16'hDEAD;
    bus.ctl_done  = 1'b1;
    @(negedge clk_50);
    bus.ctl_done  = 1'b0;
    check("t4_late_done", {bus.rsp_valid, bus.rsp_rdata, state_dbg}, {1'b0, 16'h0000, ST_ISSUE});
    @(negedge clk_50);
    check("t4_next_op", {bus.ctl_start, bus.ctl_we, bus.ctl_addr, bus.ctl_wdata},
          {1'b1, 1'b1, 20'h0BEEF, 16'h7777});
    repeat (2) @(negedge clk_50);
    pulse_done(16'h0000);
    verify_tail(16'h7777);
    check("t4_sticky", {timeout_err, bus.rsp_rdata}, {1'b1, 16'h0000});

    // 5: reset while waiting drops the op
    push_op(1'b0, 20'h33333, 16'h0000);
    wait_start("t5_start");
    repeat (3) @(negedge clk_50);
    rst_n = 1'b0;
    #2;
    check("t5_rst_ctl", {bus.req_ready, bus.ctl_start, bus.ctl_we, bus.ctl_addr, bus.ctl_wdata},
          {1'b1, 38'd0});
    check("t5_rst_flags", {bus.rsp_valid, bus.rsp_rdata, busy, timeout_err, verify_err, state_dbg},
          {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, ST_IDLE});
    @(negedge clk_50);
    rst_n = 1'b1;
    pulse_done(16'h1111);
    check("t5_no_rsp", {bus.rsp_valid, state_dbg}, {1'b0, ST_IDLE});
    repeat (3) @(negedge clk_50);
    check("t5_fifo_empty", {busy, bus.ctl_start, bus.rsp_rdata}, {1'b0, 1'b0, 16'h0000});

`ifdef SRAM_SEQ_VERIFY_EN
    // 6: write-verify, matching then mismatching read-back
    push_op(1'b1, 20'h44444, 16'hAAAA);
    wait_start("t6_start_a");
    repeat (2) @(negedge clk_50);
    pulse_done(16'h0000);
    wait_start("t6_vstart_a");
    check("t6_vctl", {bus.ctl_we, bus.ctl_addr}, {1'b0, 20'h44444});
    pulse_done(16'hAAAA);
    check("t6_match", {verify_err, bus.rsp_valid}, {1'b0, 1'b0});
    push_op(1'b1, 20'h55555, 16'hAAAA);
    wait_start("t6_start_b");
    pulse_done(16'h0000);
    wait_start("t6_vstart_b");
    pulse_done(16'hAAAB);
    check("t6_mismatch", {verify_err, bus.rsp_valid}, {1'b1, 1'b0});
    @(negedge clk_50);
    check("t6_end", {bus.rsp_valid, busy, verify_err}, {1'b0, 1'b0, 1'b1});
`else
    check("t6_verify_tied", 64'(verify_err), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
